// File: rtl/guvm_wb_pkg.sv
// Shared types and helpers for the wishbone stimulus memory.
// The response FSM states, bus widths and the default filler instruction live here.
package guvm_wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } wb_state_t;

    localparam int WB_DAT_W = 128;
    localparam int WB_SEL_W = 16;

    // ARM "mov r0,r0", returned for slots that have not been loaded yet
    localparam logic [31:0] DEFAULT_NOP_INST = 32'hE1A00000;

    function automatic logic [1:0] first_lane(input logic [WB_SEL_W-1:0] sel);
        logic [1:0] lane;
        lane = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (sel[4*k +: 4] != 4'b0000) begin
                lane = 2'(k);
            end
        end
        return lane;
    endfunction

endpackage

// File: rtl/guvm_inst_ram.sv
// Instruction buffer: one 32-bit write port and a combinational 4-word line read.
// Contents are deliberately not reset; validity is tracked by the fill counter in the top.
module guvm_inst_ram #(
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [31:0]                wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_base,
    output logic [127:0]               rd_line
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // rd_base is line aligned, so base+k never leaves the line
    always_comb begin
        rd_line = '0;
        for (int k = 0; k < 4; k++) begin
            rd_line[32*k +: 32] = mem[rd_base + AW'(k)];
        end
    end

endmodule

// File: rtl/guvm_wb_stim_mem.sv
// Wishbone slave memory model for the Amber core: serves 4-word fetch lines from a
// bench-loaded instruction buffer and captures core stores as single words.
module guvm_wb_stim_mem
    import guvm_wb_pkg::*;
#(
    parameter int          DEPTH       = 32,
    parameter int          ACK_LATENCY = 1,
    parameter logic [31:0] NOP_INST    = DEFAULT_NOP_INST
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [31:0]               ld_inst,
    input  logic [31:0]               i_wb_adr,
    input  logic [WB_SEL_W-1:0]       i_wb_sel,
    input  logic                      i_wb_we,
    input  logic [WB_DAT_W-1:0]       i_wb_dat,
    input  logic                      i_wb_cyc,
    input  logic                      i_wb_stb,
    output logic [WB_DAT_W-1:0]       o_wb_dat,
    output logic                      o_wb_ack,
    output logic                      o_wb_err,
    output logic                      st_valid,
    output logic [31:0]               st_addr,
    output logic [31:0]               st_data,
    output logic [$clog2(DEPTH):0]    fill_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_state_t state, next_state;

    logic [2:0]          wait_cnt;
    logic [27:0]         req_line;
    logic [WB_SEL_W-1:0] req_sel;
    logic                req_we;
    logic [WB_DAT_W-1:0] req_dat;

    logic                req_active;
    logic                accept_req;
    logic                resp_fire;
    logic                wait_dec;
    logic                ld_fire;
    logic                line_oob;
    logic [AW-1:0]       line_base;
    logic [127:0]        rd_line;
    logic [127:0]        read_line;
    logic [1:0]          lane;
    logic [31:0]         store_word;
    logic                adr_unused;

    assign adr_unused = ^i_wb_adr[3:0];
    assign req_active = i_wb_cyc && i_wb_stb;
    assign ld_ready   = fill_count < CW'(DEPTH);
    assign ld_fire    = ld_valid && ld_ready;

    guvm_inst_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ld_fire),
        .wr_addr (fill_count[AW-1:0]),
        .wr_data (ld_inst),
        .rd_base (line_base),
        .rd_line (rd_line)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req_active) next_state = WAIT;
            WAIT: begin
                if (!req_active) begin
                    next_state = IDLE;
                end else if (wait_cnt == 3'd0) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A dropped strobe in WAIT takes priority over the counter expiring
    always_comb begin
        accept_req = (state == IDLE) && req_active;
        resp_fire  = (state == WAIT) && req_active && (wait_cnt == 3'd0);
        wait_dec   = (state == WAIT) && req_active && (wait_cnt != 3'd0);
    end

    // Slots written on the response edge still read as NOP, since fill_count is pre-edge here
    always_comb begin
        line_oob  = req_line >= 28'(DEPTH / 4);
        line_base = AW'({req_line, 2'b00});
        read_line = '0;
        for (int k = 0; k < 4; k++) begin
            if ({1'b0, line_base + AW'(k)} < fill_count) begin
                read_line[32*k +: 32] = rd_line[32*k +: 32];
            end else begin
                read_line[32*k +: 32] = NOP_INST;
            end
        end
    end

    always_comb begin
        lane       = first_lane(req_sel);
        store_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (req_sel[{lane, 2'(b)}]) begin
                store_word[8*b +: 8] = req_dat[{lane, 2'(b), 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt   <= '0;
            req_line   <= '0;
            req_sel    <= '0;
            req_we     <= 1'b0;
            req_dat    <= '0;
            o_wb_dat   <= '0;
            o_wb_ack   <= 1'b0;
            o_wb_err   <= 1'b0;
            st_valid   <= 1'b0;
            st_addr    <= '0;
            st_data    <= '0;
            fill_count <= '0;
        end else begin
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            st_valid <= 1'b0;

            if (ld_fire) begin
                fill_count <= fill_count + CW'(1);
            end

            if (accept_req) begin
                req_line <= i_wb_adr[31:4];
                req_sel  <= i_wb_sel;
                req_we   <= i_wb_we;
                req_dat  <= i_wb_dat;
                wait_cnt <= 3'(ACK_LATENCY - 1);
            end else if (wait_dec) begin
                wait_cnt <= wait_cnt - 3'd1;
            end

            if (resp_fire) begin
                if (req_we) begin
                    o_wb_ack <= 1'b1;
                    if (req_sel != '0) begin
                        st_valid <= 1'b1;
                        st_addr  <= {req_line, lane, 2'b00};
                        st_data  <= store_word;
                    end
                end else if (line_oob) begin
                    o_wb_err <= 1'b1;
                end else begin
                    o_wb_ack <= 1'b1;
                    o_wb_dat <= read_line;
                end
            end
        end
    end

endmodule

// File: tb/tb_guvm_wb_stim_mem.sv
// Scoreboard bench for guvm_wb_stim_mem: a driver predicts each bus response from a
// word-array model and queues it; a monitor pops and compares whenever ack/err appears.
module tb_guvm_wb_stim_mem;

    localparam int          DEPTH = 32;
    localparam int          LAT   = 4;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'hE1A00000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [31:0]   ld_inst = '0;
    logic [31:0]   i_wb_adr = '0;
    logic [15:0]   i_wb_sel = '0;
    logic          i_wb_we = 1'b0;
    logic [127:0]  i_wb_dat = '0;
    logic          i_wb_cyc = 1'b0;
    logic          i_wb_stb = 1'b0;
    logic [127:0]  o_wb_dat;
    logic          o_wb_ack;
    logic          o_wb_err;
    logic          st_valid;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [CW-1:0] fill_count;

    always #5 clk = ~clk;

    guvm_wb_stim_mem #(
        .DEPTH       (DEPTH),
        .ACK_LATENCY (LAT),
        .NOP_INST    (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_inst    (ld_inst),
        .i_wb_adr   (i_wb_adr),
        .i_wb_sel   (i_wb_sel),
        .i_wb_we    (i_wb_we),
        .i_wb_dat   (i_wb_dat),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .o_wb_dat   (o_wb_dat),
        .o_wb_ack   (o_wb_ack),
        .o_wb_err   (o_wb_err),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .fill_count (fill_count)
    );

    typedef struct {
        logic         is_err;
        logic [127:0] dat;
        logic         st_valid;
        logic [31:0]  st_addr;
        logic [31:0]  st_data;
        int           edge_no;
    } exp_t;

    exp_t sb[$];

    int n_compared   = 0;
    int n_mismatched = 0;
    int edge_cnt     = 0;

    logic [31:0]  model_mem [DEPTH];
    int           model_fill = 0;
    logic [127:0] last_dat   = '0;

    always @(posedge clk) edge_cnt++;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
        n_compared++;
        if (actual !== required) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    // Monitor: every ack/err must match the oldest outstanding prediction
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset && (o_wb_ack || o_wb_err)) begin
            if (sb.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_resp: got ack=%0b err=%0b, required no response", o_wb_ack, o_wb_err);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("resp_ack", o_wb_ack, !mon_e.is_err);
                checkOutput("resp_err", o_wb_err, mon_e.is_err);
                checkOutput("resp_dat", o_wb_dat, mon_e.dat);
                checkOutput("resp_edge", 128'(edge_cnt), 128'(mon_e.edge_no));
                checkOutput("st_valid", st_valid, mon_e.st_valid);
                if (mon_e.st_valid) begin
                    checkOutput("st_addr", st_addr, mon_e.st_addr);
                    checkOutput("st_data", st_data, mon_e.st_data);
                end
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [15:0] sel, input logic [127:0] dat);
        exp_t    e;
        bit      got;
        longint  line;
        int      idx;
        int      lane;
        e.is_err   = 1'b0;
        e.st_valid = 1'b0;
        e.st_addr  = '0;
        e.st_data  = '0;
        e.dat      = last_dat;
        if (!we) begin
            line = longint'(adr >> 4);
            if (line * 4 >= DEPTH) begin
                e.is_err = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    idx = int'(line * 4) + k;
                    e.dat[32*k +: 32] = (idx < model_fill) ? model_mem[idx] : NOP;
                end
                last_dat = e.dat;
            end
        end else if (sel != 16'h0000) begin
            lane = 0;
            while (sel[4*lane +: 4] == 4'h0) lane++;
            e.st_valid = 1'b1;
            e.st_addr  = (adr & 32'hFFFF_FFF0) + 32'(4 * lane);
            for (int b = 0; b < 4; b++) begin
                e.st_data[8*b +: 8] = sel[4*lane + b] ? dat[32*lane + 8*b +: 8] : 8'h00;
            end
        end
        @(negedge clk);
        i_wb_adr = adr;
        i_wb_sel = sel;
        i_wb_we  = we;
        i_wb_dat = dat;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        e.edge_no = edge_cnt + 1 + LAT;
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < LAT + 8; i++) begin
            @(negedge clk);
            if (o_wb_ack || o_wb_err) begin
                got = 1'b1;
                break;
            end
        end
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        if (!got) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL resp_timeout: got no ack/err for adr %h, required a response", adr);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic loadInst(input logic [31:0] inst);
        @(negedge clk);
        checkOutput("ld_ready", ld_ready, model_fill < DEPTH);
        checkOutput("fill_count", fill_count, 128'(model_fill));
        ld_valid = 1'b1;
        ld_inst  = inst;
        @(posedge clk);
        if (model_fill < DEPTH) begin
            model_mem[model_fill] = inst;
            model_fill++;
        end
        #1 ld_valid = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset    = 1'b1;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        ld_valid = 1'b0;
        @(negedge clk);
        reset      = 1'b0;
        model_fill = 0;
        last_dat   = '0;
        sb.delete();
    endtask

    task automatic checkResetState();
        checkOutput("rst_ack", o_wb_ack, 1'b0);
        checkOutput("rst_err", o_wb_err, 1'b0);
        checkOutput("rst_st_valid", st_valid, 1'b0);
        checkOutput("rst_dat", o_wb_dat, '0);
        checkOutput("rst_st_addr", st_addr, '0);
        checkOutput("rst_st_data", st_data, '0);
        checkOutput("rst_fill", fill_count, '0);
        checkOutput("rst_ld_ready", ld_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          r;
        logic [31:0] adr;
        logic [15:0] sel;

        repeat (3) @(negedge clk);
        doReset();
        checkResetState();

        // Directed fetches over a partial fill, including the out-of-range line
        for (int i = 0; i < 8; i++) loadInst(32'h11 + 32'(i));
        applyStimulus(1'b0, 32'h0000_0000, 16'hFFFF, '0);
        applyStimulus(1'b0, 32'h0000_0010, 16'h0000, '0);
        applyStimulus(1'b0, 32'h0000_0020, 16'hFFFF, '0);
        applyStimulus(1'b0, 32'h0000_0080, 16'hFFFF, '0);

        // Stores: full lane, partial lane, and no enables
        applyStimulus(1'b1, 32'h0000_0104, 16'h00F0, 128'hDEADBEEF << 32);
        applyStimulus(1'b1, 32'h0000_0104, 16'h0030, 128'hDEADBEEF << 32);
        applyStimulus(1'b1, 32'h0000_0200, 16'h0000, 128'h1234);

        // Strobe dropped while waiting: nothing may come back
        @(negedge clk);
        i_wb_adr = 32'h10; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        @(negedge clk);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        repeat (LAT + 3) begin
            @(negedge clk);
            checkOutput("abort_no_resp", {o_wb_ack, o_wb_err}, 2'b00);
        end
        applyStimulus(1'b0, 32'h0000_0010, 16'hFFFF, '0);

        // Fill to capacity, then one more offer that must be ignored
        while (model_fill < DEPTH) loadInst(32'h100 + 32'(model_fill));
        loadInst(32'hBAD0_BAD0);
        @(negedge clk);
        checkOutput("full_fill", fill_count, 128'(DEPTH));
        checkOutput("full_ld_ready", ld_ready, 1'b0);
        applyStimulus(1'b0, 32'h0000_0070, 16'hFFFF, '0);

        // Reset while a fetch sits in WAIT
        doReset();
        for (int i = 0; i < 5; i++) loadInst(32'hA0 + 32'(i));
        @(negedge clk);
        i_wb_adr = 32'h0; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        @(negedge clk);
        reset = 1'b0; model_fill = 0; last_dat = '0;
        checkResetState();
        repeat (LAT + 2) begin
            @(negedge clk);
            checkOutput("reset_no_resp", {o_wb_ack, o_wb_err}, 2'b00);
        end
        applyStimulus(1'b0, 32'h0000_0000, 16'hFFFF, '0);

        // Randomized mix of loads, fetches, stores and occasional resets
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                loadInst($urandom);
            end else if (r < 6) begin
                adr = 32'($urandom_range(0, DEPTH * 4 + 63));
                if ($urandom_range(0, 15) == 0) adr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                applyStimulus(1'b0, adr, 16'($urandom), '0);
            end else if (r < 9) begin
                sel = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
                applyStimulus(1'b1, $urandom, sel, {$urandom, $urandom, $urandom, $urandom});
            end else if ($urandom_range(0, 3) == 0) begin
                doReset();
                checkResetState();
            end
        end

        repeat (4) @(negedge clk);
        checkOutput("sb_drained", 128'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
